// File: rtl/axi_burst_reader_if.sv
// rtl/axi_burst_reader_if.sv - AXI4 read address/data channel bundle with master/slave views
interface axi_burst_reader_if #(
    parameter int AXI_AWIDTH = 64,
    parameter int AXI_DWIDTH = 64
);
    logic [3:0]            m_arid;
    logic [AXI_AWIDTH-1:0] m_araddr;
    logic [7:0]            m_arlen;
    logic [2:0]            m_arsize;
    logic [1:0]            m_arburst;
    logic                  m_arvalid;
    logic                  m_arready;
    logic [AXI_DWIDTH-1:0] m_rdata;
    logic [1:0]            m_rresp;
    logic                  m_rlast;
    logic                  m_rvalid;
    logic                  m_rready;

    modport master (
        output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
        input  m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
    );

    modport slave (
        input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
        output m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
    );
endinterface

// File: rtl/axi_burst_reader.sv
// rtl/axi_burst_reader.sv - splits a linear read command into 4KB-safe AXI INCR bursts and streams beats out
module axi_burst_reader #(
    parameter int AXI_AWIDTH = 64,
    parameter int AXI_DWIDTH = 64,
    parameter int MAX_BURST  = 16,
    parameter int LEN_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AXI_AWIDTH-1:0] cmd_addr,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    axi_burst_reader_if.master    m_axi,
    output logic [AXI_DWIDTH-1:0] dout_data,
    output logic                  dout_last,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int BYTE_SIZE      = AXI_DWIDTH / 8;
    localparam int LOG2_BYTE_SIZE = $clog2(BYTE_SIZE);
    localparam int CW             = (LEN_W > 13) ? LEN_W : 13;

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [AXI_AWIDTH-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]      rem_q, rem_d;
    logic [8:0]            beat_cnt_q, beat_cnt_d;
    logic                  err_q, err_d;

    logic [12:0]           beats_to_4k;
    logic [8:0]            burst;
    logic                  last_burst;
    logic                  ar_valid;
    logic                  r_ready;
    logic                  r_fire;

    // Burst length from registered state only, so the AR payload cannot move while arvalid is held
    always_comb begin
        beats_to_4k = (13'd4096 - {1'b0, addr_q[11:0]}) >> LOG2_BYTE_SIZE;
        burst       = 9'(MAX_BURST);
        if (beats_to_4k < 13'(burst)) begin
            burst = beats_to_4k[8:0];
        end
        if (CW'(rem_q) < CW'(burst)) begin
            burst = rem_q[8:0];
        end
        last_burst = (CW'(rem_q) == CW'(burst));
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    // Next-state, burst bookkeeping and handshake outputs
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        cmd_ready  = 1'b0;
        ar_valid   = 1'b0;
        r_ready    = 1'b0;
        dout_valid = 1'b0;
        dout_last  = 1'b0;
        done       = 1'b0;
        r_fire     = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d  = cmd_addr & ~AXI_AWIDTH'(BYTE_SIZE - 1);
                    rem_d   = cmd_len;
                    err_d   = 1'b0;
                    state_d = (cmd_len == '0) ? S_DONE : S_AR;
                end
            end
            S_AR: begin
                ar_valid = 1'b1;
                if (m_axi.m_arready) begin
                    beat_cnt_d = '0;
                    state_d    = S_R;
                end
            end
            S_R: begin
                // Output stream is a straight pass-through; downstream stall stalls the slave
                r_ready    = dout_ready;
                dout_valid = m_axi.m_rvalid;
                dout_last  = m_axi.m_rlast & last_burst;
                r_fire     = m_axi.m_rvalid & dout_ready;
                if (r_fire) begin
                    beat_cnt_d = beat_cnt_q + 9'd1;
                    if (m_axi.m_rresp != 2'b00) begin
                        err_d = 1'b1;
                    end
                    if (m_axi.m_rlast) begin
                        // A short or long burst is flagged but still treated as complete
                        if (beat_cnt_q != (burst - 9'd1)) begin
                            err_d = 1'b1;
                        end
                        addr_d  = addr_q + (AXI_AWIDTH'(burst) << LOG2_BYTE_SIZE);
                        rem_d   = rem_q - LEN_W'(burst);
                        state_d = last_burst ? S_DONE : S_AR;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign m_axi.m_arid    = 4'd0;
    assign m_axi.m_araddr  = addr_q;
    assign m_axi.m_arlen   = 8'(burst - 9'd1);
    assign m_axi.m_arsize  = 3'(LOG2_BYTE_SIZE);
    assign m_axi.m_arburst = 2'b01;
    assign m_axi.m_arvalid = ar_valid;
    assign m_axi.m_rready  = r_ready;

    assign dout_data = m_axi.m_rdata;
    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;
endmodule

// File: tb/tb_axi_burst_reader.sv
// tb/tb_axi_burst_reader.sv - scoreboard bench for axi_burst_reader with a behavioural AXI read slave
module tb_axi_burst_reader;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int LW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [DW-1:0] dout_data;
    logic          dout_last;
    logic          dout_valid;
    logic          dout_ready = 1'b1;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    axi_burst_reader_if #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) axi ();

    axi_burst_reader #(
        .AXI_AWIDTH(AW), .AXI_DWIDTH(DW), .MAX_BURST(16), .LEN_W(LW)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .m_axi(axi),
        .dout_data(dout_data), .dout_last(dout_last), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct { logic [63:0] addr; logic [7:0] len; } ar_t;
    typedef struct { logic [63:0] data; logic last; } beat_t;

    ar_t   exp_ar[$];
    beat_t exp_dout[$];
    logic  exp_done[$];

    int n_tests = 0;
    int n_fail  = 0;
    int dout_cnt = 0;

    bit rand_ready = 0;
    bit early_last = 0;
    int err_beat   = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ar(input logic [63:0] a, input logic [7:0] l);
        ar_t e;
        e.addr = a;
        e.len  = l;
        exp_ar.push_back(e);
    endtask

    task automatic push_beats(input logic [63:0] a, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = (a >> 3) + 64'(i);
            b.last = (i == n - 1);
            exp_dout.push_back(b);
        end
    endtask

    // Output stream backpressure
    initial begin
        forever begin
            @(negedge clk);
            dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Behavioural AXI slave: memory word at byte address A reads back as A>>3
    initial begin : slave
        bit          active;
        bit          hold;
        bit          v;
        logic [63:0] cur;
        int          left;
        int          beat_idx;
        active = 0; hold = 0; v = 0; cur = '0; left = 0; beat_idx = 0;
        axi.m_arready = 1'b0;
        axi.m_rvalid  = 1'b0;
        axi.m_rdata   = '0;
        axi.m_rresp   = 2'b00;
        axi.m_rlast   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 0; hold = 0; v = 0;
                axi.m_arready = 1'b0;
                axi.m_rvalid  = 1'b0;
                axi.m_rlast   = 1'b0;
                axi.m_rresp   = 2'b00;
                continue;
            end
            if (!active) begin
                axi.m_arready = 1'($urandom_range(0, 1));
                axi.m_rvalid  = 1'b0;
                axi.m_rlast   = 1'b0;
            end else begin
                axi.m_arready = 1'b0;
                if (!hold) v = ($urandom_range(0, 3) != 0);
                axi.m_rvalid = v;
                axi.m_rdata  = cur >> 3;
                axi.m_rlast  = (left == 1);
                axi.m_rresp  = (beat_idx == err_beat) ? 2'b10 : 2'b00;
            end
            #1;
            if (!active && axi.m_arvalid && axi.m_arready) begin
                active   = 1;
                hold     = 0;
                cur      = axi.m_araddr;
                left     = int'(axi.m_arlen) + 1 - (early_last ? 1 : 0);
                beat_idx = 0;
            end else if (active) begin
                if (axi.m_rvalid && axi.m_rready) begin
                    hold = 0;
                    cur  = cur + 64'd8;
                    left--;
                    beat_idx++;
                    if (left == 0) active = 0;
                end else begin
                    hold = v;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a handshake
    initial begin : monitor
        bit          ar_wait;
        bit          done_next;
        bit          ar_next;
        logic [63:0] prev_addr;
        logic [7:0]  prev_len;
        ar_t         ea;
        beat_t       eb;
        logic        ee;
        ar_wait = 0; done_next = 0; ar_next = 0; prev_addr = '0; prev_len = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                ar_wait = 0; done_next = 0; ar_next = 0;
                continue;
            end
            if (done_next) check("done_after_final_rlast", done, 1);
            if (ar_next)   check("arvalid_after_rlast", axi.m_arvalid, 1);
            done_next = 0;
            ar_next   = 0;

            if (axi.m_arvalid) begin
                if (ar_wait) begin
                    check("ar_addr_stable", axi.m_araddr, prev_addr);
                    check("ar_len_stable", axi.m_arlen, prev_len);
                end
                if (axi.m_arready) begin
                    ar_wait = 0;
                    if (exp_ar.size() == 0) begin
                        check("unexpected_ar", axi.m_araddr, 64'hdead);
                    end else begin
                        ea = exp_ar.pop_front();
                        check("araddr", axi.m_araddr, ea.addr);
                        check("arlen", axi.m_arlen, ea.len);
                        check("arsize", axi.m_arsize, 3);
                        check("arburst", axi.m_arburst, 1);
                        check("arid", axi.m_arid, 0);
                    end
                end else begin
                    ar_wait   = 1;
                    prev_addr = axi.m_araddr;
                    prev_len  = axi.m_arlen;
                end
            end

            if (axi.m_rvalid) begin
                check("rready_mirrors_dout_ready", axi.m_rready, dout_ready);
                check("dout_valid_pass", dout_valid, 1);
            end

            if (dout_valid && dout_ready) begin
                dout_cnt++;
                if (exp_dout.size() == 0) begin
                    check("unexpected_beat", dout_data, 64'hdead);
                end else begin
                    eb = exp_dout.pop_front();
                    check("dout_data", dout_data, eb.data);
                    check("dout_last", dout_last, eb.last);
                    if (axi.m_rlast) begin
                        if (eb.last) done_next = 1;
                        else         ar_next   = 1;
                    end
                end
            end

            if (done) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    ee = exp_done.pop_front();
                    check("err_at_done", err, ee);
                end
            end
        end
    end

    task automatic start_cmd(input logic [63:0] a, input logic [31:0] l);
        @(negedge clk);
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        #1;
        check("cmd_ready_idle", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        if (l == 0) begin
            check("zero_len_done_n1", done, 1);
            check("zero_len_busy_n1", busy, 1);
            check("zero_len_no_ar", axi.m_arvalid, 0);
        end else begin
            check("arvalid_n1", axi.m_arvalid, 1);
        end
    endtask

    task automatic run_cmd(input logic [63:0] a, input logic [31:0] l);
        bit seen;
        start_cmd(a, l);
        if (l != 0) begin
            seen = 0;
            for (int i = 0; i < 3000; i++) begin
                @(negedge clk);
                #1;
                if (done) begin
                    seen = 1;
                    break;
                end
            end
            check("done_within_budget", seen, 1);
        end
        @(negedge clk);
        #1;
        check("cmd_ready_after_done", cmd_ready, 1);
        check("busy_after_done", busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_arvalid"}, axi.m_arvalid, 0);
        check({tag, "_rready"}, axi.m_rready, 0);
        check({tag, "_dout_valid"}, dout_valid, 0);
        check({tag, "_dout_last"}, dout_last, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int start;
        bit reached;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #2 rst = 1'b0;

        // single burst
        push_ar(64'h1000, 8'd3);
        push_beats(64'h1000, 4);
        exp_done.push_back(1'b0);
        run_cmd(64'h1000, 4);

        // three bursts capped by MAX_BURST
        push_ar(64'h000, 8'd15);
        push_ar(64'h080, 8'd15);
        push_ar(64'h100, 8'd7);
        push_beats(64'h0, 40);
        exp_done.push_back(1'b0);
        run_cmd(64'h0, 40);

        // 4KB boundary split
        push_ar(64'hFE0, 8'd3);
        push_ar(64'h1000, 8'd5);
        push_beats(64'hFE0, 10);
        exp_done.push_back(1'b0);
        run_cmd(64'hFE0, 10);

        // zero length
        exp_done.push_back(1'b0);
        run_cmd(64'h2345, 0);

        // random output backpressure, unaligned low bits dropped
        rand_ready = 1;
        push_ar(64'h4000, 8'd15);
        push_ar(64'h4080, 8'd15);
        push_beats(64'h4000, 32);
        exp_done.push_back(1'b0);
        run_cmd(64'h4005, 32);
        rand_ready = 0;

        // SLVERR on beat 2
        err_beat = 1;
        push_ar(64'h5000, 8'd3);
        push_beats(64'h5000, 4);
        exp_done.push_back(1'b1);
        run_cmd(64'h5000, 4);
        err_beat = -1;

        // err cleared by the next command
        push_ar(64'h7000, 8'd0);
        push_beats(64'h7000, 1);
        exp_done.push_back(1'b0);
        run_cmd(64'h7000, 1);

        // slave ends the burst one beat early
        early_last = 1;
        push_ar(64'h2000, 8'd3);
        push_beats(64'h2000, 3);
        exp_done.push_back(1'b1);
        run_cmd(64'h2000, 4);
        early_last = 0;

        // reset mid-burst
        push_ar(64'h3000, 8'd7);
        push_beats(64'h3000, 8);
        start = dout_cnt;
        start_cmd(64'h3000, 8);
        reached = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            if (dout_cnt >= start + 3) begin
                reached = 1;
                break;
            end
        end
        check("beats_before_reset", reached, 1);
        #2 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("midreset");
        exp_ar.delete();
        exp_dout.delete();
        exp_done.delete();
        @(posedge clk);
        #2 rst = 1'b0;

        // normal operation after reset
        push_ar(64'h8000, 8'd2);
        push_beats(64'h8000, 3);
        exp_done.push_back(1'b0);
        run_cmd(64'h8000, 3);

        repeat (3) @(negedge clk);
        check("ar_queue_empty", exp_ar.size(), 0);
        check("dout_queue_empty", exp_dout.size(), 0);
        check("done_queue_empty", exp_done.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
